// File: rtl/regfile_pkg.sv
// Shared constants and the write-back entry type for the register-file write path.
package regfile_pkg;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    typedef struct packed {
        logic [AW-1:0]    wn;
        logic [WIDTH-1:0] d;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer holding mul/div results waiting for the regfile write port.
// Exposes per-entry valid/wn so the hazard unit can search queued destinations.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = regfile_pkg::WIDTH,
    parameter int AW    = regfile_pkg::AW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [AW-1:0]          push_wn,
    input  logic [WIDTH-1:0]       push_d,
    output logic [AW-1:0]          head_wn,
    output logic [WIDTH-1:0]       head_d,
    output logic                   full,
    output logic                   empty,
    output logic                   can_push,
    output logic [CW-1:0]          count,
    output logic [DEPTH-1:0]       valid,
    output logic [DEPTH-1:0][AW-1:0] wn_vec
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_nxt;
    logic [AW-1:0]    mem_wn [DEPTH];
    logic [WIDTH-1:0] mem_d  [DEPTH];
    logic [PW-1:0]    off    [DEPTH];

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign head_wn = mem_wn[rd_ptr];
    assign head_d  = mem_d[rd_ptr];

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    // Pointers, occupancy and the registered accept flag (low while in reset).
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            can_push <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            can_push <= (count_nxt < DEPTH_C);
        end
    end

    // Entry storage: only the tail slot is written on a push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy and pointers alone decide which slots are live.
        if (push) begin
            mem_wn[wr_ptr] <= push_wn;
            mem_d[wr_ptr]  <= push_d;
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            off[i]    = PW'(i) - rd_ptr;
            valid[i]  = ({1'b0, off[i]} < count);
            wn_vec[i] = mem_wn[i];
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and queued mul/div results onto the
// single registered regfile write port, and answers pending-write queries.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int WIDTH = regfile_pkg::WIDTH,
    parameter int AW    = regfile_pkg::AW
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         alu_valid,
    input  logic [AW-1:0]                alu_wn,
    input  logic [WIDTH-1:0]             alu_d,
    output logic                         alu_stall,
    input  logic                         md_valid,
    output logic                         md_ready,
    input  logic [AW-1:0]                md_wn,
    input  logic [WIDTH-1:0]             md_d,
    output logic [AW-1:0]                wn,
    output logic [WIDTH-1:0]             d,
    output logic                         we,
    input  logic [AW-1:0]                qn,
    output logic                         q_pend,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    logic                    full;
    logic                    empty;
    logic                    can_push;
    logic                    push;
    logic                    pop;
    logic                    alu_nz;
    logic                    alu_go;
    logic                    hit;
    logic [AW-1:0]           head_wn;
    logic [WIDTH-1:0]        head_d;
    logic [DEPTH-1:0]        valid;
    logic [DEPTH-1:0][AW-1:0] wn_vec;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .clr      (clr),
        .push     (push),
        .pop      (pop),
        .push_wn  (md_wn),
        .push_d   (md_d),
        .head_wn  (head_wn),
        .head_d   (head_d),
        .full     (full),
        .empty    (empty),
        .can_push (can_push),
        .count    (count),
        .valid    (valid),
        .wn_vec   (wn_vec)
    );

    // r0 results are consumed without a write; a full FIFO takes the port from the ALU.
    assign md_ready  = can_push;
    assign alu_nz    = alu_valid & (alu_wn != '0);
    assign alu_go    = alu_nz & ~full;
    assign alu_stall = alu_nz & full;
    assign pop       = full | (~alu_go & ~empty);
    assign push      = md_valid & md_ready & (md_wn != '0);

    // Output register: head when full, else ALU, else head, else idle holding wn/d.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            we <= 1'b0;
            wn <= '0;
            d  <= '0;
        end else if (pop) begin
            we <= 1'b1;
            wn <= head_wn;
            d  <= head_d;
        end else if (alu_go) begin
            we <= 1'b1;
            wn <= alu_wn;
            d  <= alu_d;
        end else begin
            we <= 1'b0;
        end
    end

    // Pending query: any live queued entry or the in-flight write targets qn.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (wn_vec[i] == qn))
                hit = 1'b1;
        end
        q_pend = (qn != '0) & (hit | (we & (wn == qn)));
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of the write-back rules.
module tb_wb_arbiter;
    import regfile_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             clr;
    logic             alu_valid;
    logic [AW-1:0]    alu_wn;
    logic [WIDTH-1:0] alu_d;
    logic             alu_stall;
    logic             md_valid;
    logic             md_ready;
    logic [AW-1:0]    md_wn;
    logic [WIDTH-1:0] md_d;
    logic [AW-1:0]    wn;
    logic [WIDTH-1:0] d;
    logic             we;
    logic [AW-1:0]    qn;
    logic             q_pend;
    logic [CW-1:0]    count;

    wb_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .clr(clr),
        .alu_valid(alu_valid), .alu_wn(alu_wn), .alu_d(alu_d), .alu_stall(alu_stall),
        .md_valid(md_valid), .md_ready(md_ready), .md_wn(md_wn), .md_d(md_d),
        .wn(wn), .d(d), .we(we), .qn(qn), .q_pend(q_pend), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queued results in order, plus the write-port contents.
    wb_entry_t        mq[$];
    logic             m_we;
    logic [AW-1:0]    m_wn;
    logic [WIDTH-1:0] m_d;

    function automatic logic m_full();
        return mq.size() == DEPTH;
    endfunction

    function automatic logic m_stall();
        return alu_valid && (alu_wn != 0) && m_full();
    endfunction

    function automatic logic m_pend(input logic [AW-1:0] q);
        if (q == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].wn == q) return 1'b1;
        return m_we && (m_wn == q);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0;
        m_wn = '0;
        m_d  = '0;
    endtask

    task automatic model_step();
        wb_entry_t e;
        logic      do_push;
        do_push = md_valid && (mq.size() < DEPTH) && (md_wn != 0);
        if (m_full()) begin
            e = mq.pop_front();
            m_we = 1'b1; m_wn = e.wn; m_d = e.d;
        end else if (alu_valid && alu_wn != 0) begin
            m_we = 1'b1; m_wn = alu_wn; m_d = alu_d;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_wn = e.wn; m_d = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (do_push) begin
            e.wn = md_wn; e.d = md_d;
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [AW-1:0] w, input logic [WIDTH-1:0] x);
        alu_valid = v; alu_wn = w; alu_d = x;
    endtask

    task automatic set_md(input logic v, input logic [AW-1:0] w, input logic [WIDTH-1:0] x);
        md_valid = v; md_wn = w; md_d = x;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        set_alu(1'b0, '0, '0);
        set_md(1'b0, '0, '0);
        qn = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({we, wn, d, count, md_ready, alu_stall} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got we=%b wn=%0d d=%h count=%0d md_ready=%b alu_stall=%b want all 0",
                     we, wn, d, count, md_ready, alu_stall);
        end
        clr = 1'b0;
        tick();
        n_cmp++;
        if ({md_ready, we, count} !== {1'b1, 1'b0, CW'(0)}) begin
            n_bad++;
            $display("FAIL reset_release: got md_ready=%b we=%b count=%0d want 1 0 0", md_ready, we, count);
        end
    endtask

    task automatic test_alu_only();
        set_alu(1'b1, 5'd7, 32'h1234);
        #2;
        n_cmp++;
        if (alu_stall !== 1'b0) begin
            n_bad++; $display("FAIL alu_stall_idle: got %b want 0", alu_stall);
        end
        tick();
        n_cmp++;
        if ({we, wn, d} !== {1'b1, 5'd7, 32'h1234}) begin
            n_bad++; $display("FAIL alu_write: got we=%b wn=%0d d=%h want 1 7 1234", we, wn, d);
        end
        set_alu(1'b1, 5'd0, 32'hFFFF);
        tick();
        n_cmp++;
        if ({we, wn, d} !== {1'b0, 5'd7, 32'h1234}) begin
            n_bad++; $display("FAIL alu_r0: got we=%b wn=%0d d=%h want 0 7 1234", we, wn, d);
        end
        set_alu(1'b0, '0, '0);
    endtask

    task automatic test_md_drain();
        set_md(1'b1, 5'd3, 32'hA);
        #2;
        n_cmp++;
        if (md_ready !== 1'b1) begin
            n_bad++; $display("FAIL md_ready_empty: got %b want 1", md_ready);
        end
        tick();
        n_cmp++;
        if ({we, count} !== {1'b0, CW'(1)}) begin
            n_bad++; $display("FAIL md_no_bypass: got we=%b count=%0d want 0 1", we, count);
        end
        set_md(1'b1, 5'd4, 32'hB);
        tick();
        n_cmp++;
        if ({we, wn, d, count} !== {1'b1, 5'd3, 32'hA, CW'(1)}) begin
            n_bad++; $display("FAIL md_first: got we=%b wn=%0d d=%h count=%0d want 1 3 a 1", we, wn, d, count);
        end
        set_md(1'b0, '0, '0);
        tick();
        n_cmp++;
        if ({we, wn, d, count} !== {1'b1, 5'd4, 32'hB, CW'(0)}) begin
            n_bad++; $display("FAIL md_second: got we=%b wn=%0d d=%h count=%0d want 1 4 b 0", we, wn, d, count);
        end
        tick();
        n_cmp++;
        if ({we, count} !== {1'b0, CW'(0)}) begin
            n_bad++; $display("FAIL md_idle: got we=%b count=%0d want 0 0", we, count);
        end
    endtask

    task automatic test_full_priority();
        for (int i = 0; i < DEPTH; i++) begin
            set_alu(1'b1, AW'(20 + i), WIDTH'(i));
            set_md(1'b1, AW'(10 + i), WIDTH'(100 + i));
            tick();
        end
        n_cmp++;
        if ({count, md_ready, wn} !== {CW'(4), 1'b0, 5'd23}) begin
            n_bad++; $display("FAIL full_fill: got count=%0d md_ready=%b wn=%0d want 4 0 23", count, md_ready, wn);
        end
        set_md(1'b0, '0, '0);
        set_alu(1'b1, 5'd9, 32'h99);
        #2;
        n_cmp++;
        if (alu_stall !== 1'b1) begin
            n_bad++; $display("FAIL full_stall: got %b want 1", alu_stall);
        end
        tick();
        n_cmp++;
        if ({we, wn, d, count, md_ready} !== {1'b1, 5'd10, 32'd100, CW'(3), 1'b1}) begin
            n_bad++; $display("FAIL full_pop: got we=%b wn=%0d d=%0d count=%0d md_ready=%b want 1 10 100 3 1",
                              we, wn, d, count, md_ready);
        end
        tick();
        n_cmp++;
        if ({we, wn, d, count} !== {1'b1, 5'd9, 32'h99, CW'(3)}) begin
            n_bad++; $display("FAIL full_alu_after: got we=%b wn=%0d d=%h count=%0d want 1 9 99 3", we, wn, d, count);
        end
        set_alu(1'b0, '0, '0);
        for (int k = 1; k < DEPTH; k++) begin
            tick();
            n_cmp++;
            if ({we, wn, d} !== {1'b1, AW'(10 + k), WIDTH'(100 + k)}) begin
                n_bad++; $display("FAIL full_drain%0d: got we=%b wn=%0d d=%0d want 1 %0d %0d",
                                  k, we, wn, d, 10 + k, 100 + k);
            end
        end
    endtask

    task automatic test_pending();
        set_alu(1'b1, 5'd6, 32'd6);
        set_md(1'b1, 5'd5, 32'd5);
        tick();
        set_alu(1'b0, '0, '0);
        set_md(1'b0, '0, '0);
        qn = 5'd5;
        #1;
        n_cmp++;
        if (q_pend !== 1'b1) begin n_bad++; $display("FAIL pend_queued: got %b want 1", q_pend); end
        qn = 5'd0;
        #1;
        n_cmp++;
        if (q_pend !== 1'b0) begin n_bad++; $display("FAIL pend_r0: got %b want 0", q_pend); end
        qn = 5'd6;
        #1;
        n_cmp++;
        if (q_pend !== 1'b1) begin n_bad++; $display("FAIL pend_alu_inflight: got %b want 1", q_pend); end
        qn = 5'd5;
        tick();
        n_cmp++;
        if ({we, wn, q_pend} !== {1'b1, 5'd5, 1'b1}) begin
            n_bad++; $display("FAIL pend_inflight: got we=%b wn=%0d q_pend=%b want 1 5 1", we, wn, q_pend);
        end
        tick();
        n_cmp++;
        if ({we, q_pend} !== {1'b0, 1'b0}) begin
            n_bad++; $display("FAIL pend_done: got we=%b q_pend=%b want 0 0", we, q_pend);
        end
        qn = '0;
    endtask

    task automatic test_simul_push_pop();
        set_alu(1'b1, 5'd21, 32'd21); set_md(1'b1, 5'd1, 32'h11); tick();
        set_alu(1'b1, 5'd22, 32'd22); set_md(1'b1, 5'd2, 32'h22); tick();
        n_cmp++;
        if (count !== CW'(2)) begin n_bad++; $display("FAIL simul_pre: got count=%0d want 2", count); end
        set_alu(1'b0, '0, '0); set_md(1'b1, 5'd3, 32'h33);
        tick();
        n_cmp++;
        if ({count, we, wn, d} !== {CW'(2), 1'b1, 5'd1, 32'h11}) begin
            n_bad++; $display("FAIL simul_same: got count=%0d we=%b wn=%0d d=%h want 2 1 1 11", count, we, wn, d);
        end
        set_md(1'b0, '0, '0);
        for (int k = 2; k <= 3; k++) begin
            tick();
            n_cmp++;
            if ({we, wn, d} !== {1'b1, m_wn, m_d} || m_wn != AW'(k)) begin
                n_bad++; $display("FAIL simul_order%0d: got we=%b wn=%0d d=%h want 1 %0d %h", k, we, wn, d, k, m_d);
            end
        end
        tick();
        n_cmp++;
        if ({we, count} !== {1'b0, CW'(0)}) begin
            n_bad++; $display("FAIL simul_empty: got we=%b count=%0d want 0 0", we, count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_alu(1'b1, AW'(24 + i), WIDTH'(i));
            set_md(1'b1, AW'(11 + i), WIDTH'(i));
            tick();
        end
        clr = 1'b1;
        set_alu(1'b0, '0, '0);
        set_md(1'b0, '0, '0);
        model_reset();
        #1;
        n_cmp++;
        if ({we, count, md_ready, alu_stall} !== '0) begin
            n_bad++; $display("FAIL reset_mid: got we=%b count=%0d md_ready=%b alu_stall=%b want 0 0 0 0",
                              we, count, md_ready, alu_stall);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({we, md_ready, count} !== {1'b0, 1'b1, CW'(0)}) begin
                n_bad++; $display("FAIL reset_after%0d: got we=%b md_ready=%b count=%0d want 0 1 0",
                                  k, we, md_ready, count);
            end
        end
    endtask

    task automatic test_random();
        logic held = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!held)
                set_alu($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom);
            set_md($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom);
            qn = AW'($urandom_range(0, 7));
            #2;
            n_cmp++;
            if ({alu_stall, md_ready, q_pend, count} !==
                {m_stall(), logic'(mq.size() < DEPTH), m_pend(qn), CW'(mq.size())}) begin
                n_bad++;
                $display("FAIL rand_comb c%0d: got stall=%b ready=%b pend=%b count=%0d want %b %b %b %0d",
                         c, alu_stall, md_ready, q_pend, count,
                         m_stall(), mq.size() < DEPTH, m_pend(qn), mq.size());
            end
            held = m_stall();
            tick();
            n_cmp++;
            if ({we, wn, d} !== {m_we, m_wn, m_d} || (we === 1'b1 && wn === '0)) begin
                n_bad++;
                $display("FAIL rand_port c%0d: got we=%b wn=%0d d=%h want %b %0d %h", c, we, wn, d, m_we, m_wn, m_d);
            end
        end
        set_alu(1'b0, '0, '0);
        set_md(1'b0, '0, '0);
        qn = '0;
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_md_drain();
        test_full_priority();
        test_pending();
        test_simul_push_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
